// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
//   Shares one pipelined, in-order fp_multiplier among NREQ requesters.
//   Each cycle one pending request is granted (round-robin, or fixed
//   priority when FP_MUL_ARB_FIXED_PRIO_EN is defined) and issued to the
//   multiplier. The granted index is pushed into an in-order tag FIFO.
//   Each multiplier finish pops a tag and becomes a registered one-hot
//   finish pulse toward the requester that issued the operation.
//
// Build option:
//   FP_MUL_ARB_FIXED_PRIO_EN  defined: lowest index wins, no rotation
//                             state. Undefined: round-robin from rr_ptr.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid       per-requester request, held until accepted
//   req_ready       one-hot accept strobe (combinational)
//   req_a, req_b    packed operands, requester i at [i*DW +: DW]
//   rsp_finish      one-hot result-valid pulse (registered)
//   rsp_result      shared result, valid with rsp_finish (registered)
//   mul_valid/ready multiplier issue handshake
//   mul_a, mul_b    multiplier operands (hold last issued when idle)
//   mul_finish      multiplier result strobe
//   mul_result      multiplier result
//   outstanding     issued-but-unreturned operation count
//   err_orphan      sticky: finish arrived with no tag outstanding
module fp_mul_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 64,
  parameter int TAG_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*DW-1:0]           req_a,
  input  logic [NREQ*DW-1:0]           req_b,
  output logic [NREQ-1:0]              rsp_finish,
  output logic [DW-1:0]                rsp_result,
  output logic                         mul_valid,
  input  logic                         mul_ready,
  output logic [DW-1:0]                mul_a,
  output logic [DW-1:0]                mul_b,
  input  logic                         mul_finish,
  input  logic [DW-1:0]                mul_result,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         err_orphan
);

  localparam int IW = $clog2(NREQ);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;

  logic              can_issue;
  logic              gnt_valid;
  logic [IW-1:0]     gnt_idx;
  logic              push;
  logic              pop;
  logic              orphan;
  logic [IW-1:0]     tag_mem [TAG_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [NREQ-1:0]   pop_onehot;
  logic [DW-1:0]     last_a;
  logic [DW-1:0]     last_b;
  logic [DW-1:0]     sel_a;
  logic [DW-1:0]     sel_b;

  // Full blocks issue even when a pop lands in the same cycle.
  assign can_issue = mul_ready && (outstanding != CW'(TAG_DEPTH));

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!gnt_valid && req_valid[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(i);
      end
    end
    if (!can_issue) begin
      gnt_valid = 1'b0;
    end
  end
`else
  logic [IW-1:0] rr_ptr;
  int unsigned   scan_idx;

  // Scan starts at rr_ptr and wraps past NREQ-1 back to 0.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = 32'(rr_ptr) + i;
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      if (!gnt_valid && req_valid[scan_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(scan_idx);
      end
    end
    if (!can_issue) begin
      gnt_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end
`endif

  assign push      = gnt_valid;
  assign mul_valid = gnt_valid;
  assign pop       = mul_finish && (outstanding != '0);
  assign orphan    = mul_finish && (outstanding == '0);

  // Operand mux is driven by the grant only; idle cycles present the
  // registered copy of the last issued operands.
  always_comb begin
    req_ready = '0;
    sel_a     = last_a;
    sel_b     = last_b;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_valid && gnt_idx == IW'(i)) begin
        req_ready[i] = 1'b1;
        sel_a        = req_a[i*DW +: DW];
        sel_b        = req_b[i*DW +: DW];
      end
    end
  end

  assign mul_a = sel_a;
  assign mul_b = sel_b;

  always_comb begin
    pop_onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (tag_mem[rd_ptr] == IW'(i)) begin
        pop_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      err_orphan  <= 1'b0;
      rsp_finish  <= '0;
      rsp_result  <= '0;
      last_a      <= '0;
      last_b      <= '0;
    end else begin
      rsp_finish <= '0;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        last_a <= sel_a;
        last_b <= sel_b;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        rsp_finish <= pop_onehot;
        rsp_result <= mul_result;
      end
      if (orphan) begin
        err_orphan <= 1'b1;
      end
      case ({push, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter
//   Randomized self-checking bench for fp_mul_arbiter (NREQ=4, TAG_DEPTH=4).
//   The bench plays the requesters and an in-order multiplier with a fixed
//   latency and a finish hold-off, and predicts every DUT output from a
//   queue-based reference model of the arbitration and tag-return rules.
module tb_fp_mul_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int TD   = 4;
  localparam int LAT  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*DW-1:0]    req_a = '0;
  logic [NREQ*DW-1:0]    req_b = '0;
  logic [NREQ-1:0]       rsp_finish;
  logic [DW-1:0]         rsp_result;
  logic                  mul_valid;
  logic                  mul_ready = 1'b1;
  logic [DW-1:0]         mul_a;
  logic [DW-1:0]         mul_b;
  logic                  mul_finish = 1'b0;
  logic [DW-1:0]         mul_result = '0;
  logic [$clog2(TD):0]   outstanding;
  logic                  err_orphan;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.NREQ(NREQ), .DW(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_finish(rsp_finish), .rsp_result(rsp_result),
    .mul_valid(mul_valid), .mul_ready(mul_ready),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_finish(mul_finish), .mul_result(mul_result),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // requesters
  bit          pend [NREQ];
  logic [63:0] pa   [NREQ];
  logic [63:0] pb   [NREQ];

  // reference model
  int          m_rr = 0;
  int          tagq [$];
  bit          m_err = 0;
  logic [3:0]  exp_fin = '0;
  logic [63:0] exp_res = '0;
  logic [63:0] last_a = '0;
  logic [63:0] last_b = '0;

  // multiplier model
  logic [63:0] mq_res [$];
  int          mq_due [$];
  bit          hold_fin = 0;
  bit          orphan_pulse = 0;
  int          cyc = 0;

  int          granted;
  logic [3:0]  obs_ready;

  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic logic [63:0] rand_op();
    return $realtobits(real'($urandom_range(1, 4000)) / 16.0);
  endfunction

  function automatic int model_grant();
    if (!mul_ready || tagq.size() >= TD) return -1;
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (pend[k]) return k;
`else
    for (int k = 0; k < NREQ; k++) if (pend[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
`endif
    return -1;
  endfunction

  // One clock cycle: drive inputs just after an edge, check combinational
  // outputs, advance the model at the edge, then check registered outputs.
  task automatic run_cycle();
    int g;
    bit has_tag;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = pend[i];
      req_a[i*DW +: DW]    = pa[i];
      req_b[i*DW +: DW]    = pb[i];
    end
    mul_finish = 1'b0;
    mul_result = {$urandom, $urandom};
    if (orphan_pulse) begin
      mul_finish = 1'b1;
    end else if (!hold_fin && mq_res.size() > 0 && mq_due[0] <= cyc) begin
      mul_finish = 1'b1;
      mul_result = mq_res[0];
    end
    #1;
    g = model_grant();
    obs_ready = req_ready;
    check("mul_valid", 64'(mul_valid), 64'(g >= 0));
    if (g >= 0) begin
      check("req_ready", 64'(req_ready), 64'(1) << g);
      check("mul_a", mul_a, pa[g]);
      check("mul_b", mul_b, pb[g]);
    end else begin
      check("req_ready_idle", 64'(req_ready), 64'(0));
      check("mul_a_hold", mul_a, last_a);
      check("mul_b_hold", mul_b, last_b);
    end
    @(posedge clk);
    has_tag = tagq.size() > 0;
    if (g >= 0) begin
      tagq.push_back(g);
      m_rr   = (g + 1) % NREQ;
      last_a = pa[g];
      last_b = pb[g];
      mq_res.push_back(fmul(pa[g], pb[g]));
      mq_due.push_back(cyc + LAT);
      pend[g] = 0;
    end
    exp_fin = '0;
    if (mul_finish) begin
      if (!orphan_pulse) begin
        void'(mq_res.pop_front());
        void'(mq_due.pop_front());
      end
      if (has_tag) begin
        exp_fin = 4'(1 << tagq.pop_front());
        exp_res = mul_result;
      end else begin
        m_err = 1;
      end
    end
    granted = g;
    cyc++;
    #1;
    check("rsp_finish", 64'(rsp_finish), 64'(exp_fin));
    check("rsp_result", rsp_result, exp_res);
    check("outstanding", 64'(outstanding), 64'(tagq.size()));
    check("err_orphan", 64'(err_orphan), 64'(m_err));
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    tagq.delete();
    m_rr = 0; m_err = 0; exp_fin = '0; exp_res = '0; last_a = '0; last_b = '0;
    check("rst_rsp_finish", 64'(rsp_finish), 64'(0));
    check("rst_rsp_result", rsp_result, 64'(0));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    check("rst_err_orphan", 64'(err_orphan), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int k;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    hold_fin = 0;
    k = 0;
    while ((tagq.size() > 0 || mq_res.size() > 0) && k < 50) begin
      run_cycle();
      k++;
    end
    check("drain_done", 64'(tagq.size() + mq_res.size()), 64'(0));
  endtask

  task automatic raise_all();
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i]) begin
        pend[i] = 1; pa[i] = rand_op(); pb[i] = rand_op();
      end
    end
  endtask

  initial begin
    int issues;
    bit seen;
    logic [3:0] seq [6];
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0; pa[i] = '0; pb[i] = '0;
    end
    do_reset();
    run_cycle();

    // single request: requester 2, 2.0 * 3.0
    pend[2] = 1; pa[2] = 64'h4000000000000000; pb[2] = 64'h4008000000000000;
    run_cycle();
    check("single_ready", 64'(obs_ready), 64'h4);
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      run_cycle();
      if (rsp_finish == 4'b0100) begin
        seen = 1;
        check("single_result", rsp_result, 64'h4018000000000000);
        check("single_latency", 64'(k), 64'(LAT - 1));
      end
    end
    check("single_seen", 64'(seen), 64'(1));
    drain();

    // mul_ready low with two requests pending
    do_reset();
    pend[0] = 1; pa[0] = rand_op(); pb[0] = rand_op();
    pend[1] = 1; pa[1] = rand_op(); pb[1] = rand_op();
    mul_ready = 1'b0;
    for (int k = 0; k < 5; k++) run_cycle();
    mul_ready = 1'b1;
    run_cycle();
    check("ready_low_first", 64'(obs_ready), 64'h1);
    drain();

    // fairness: all four held
    do_reset();
    for (int k = 0; k < 6; k++) begin
      raise_all();
      run_cycle();
      seq[k] = obs_ready;
    end
    for (int k = 0; k < 6; k++) begin
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
      check("fair_order", 64'(seq[k]), 64'h1);
`else
      check("fair_order", 64'(seq[k]), 64'(1) << (k % NREQ));
`endif
    end
    drain();

    // tag FIFO full with finishes held off
    hold_fin = 1;
    issues = 0;
    for (int k = 0; k < 7; k++) begin
      raise_all();
      run_cycle();
      if (obs_ready != 0) issues++;
    end
    check("full_issues", 64'(issues), 64'(TD));
    check("full_outstanding", 64'(outstanding), 64'(TD));
    hold_fin = 0;
    raise_all();
    run_cycle();
    check("full_pop_cycle_blocked", 64'(obs_ready), 64'(0));
    raise_all();
    run_cycle();
    check("full_resume", 64'(obs_ready != 0), 64'(1));
    drain();

    // orphan finish
    orphan_pulse = 1;
    run_cycle();
    orphan_pulse = 0;
    check("orphan_no_rsp", 64'(rsp_finish), 64'(0));
    for (int k = 0; k < 3; k++) run_cycle();
    check("orphan_sticky", 64'(err_orphan), 64'(1));

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      mul_ready = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) hold_fin = ~hold_fin;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 9) < 4) begin
          pend[i] = 1; pa[i] = rand_op(); pb[i] = rand_op();
        end
      end
      run_cycle();
    end
    mul_ready = 1'b1;
    drain();

    // reset with three ops in flight
    do_reset();
    hold_fin = 1;
    pend[0] = 1; pa[0] = rand_op(); pb[0] = rand_op();
    pend[1] = 1; pa[1] = rand_op(); pb[1] = rand_op();
    pend[3] = 1; pa[3] = rand_op(); pb[3] = rand_op();
    for (int k = 0; k < 3; k++) run_cycle();
    check("inflight_3", 64'(outstanding), 64'(3));
    do_reset();
    hold_fin = 0;
    for (int k = 0; k < 6; k++) run_cycle();
    check("stray_err", 64'(err_orphan), 64'(1));
    check("stray_drained", 64'(mq_res.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
